// File: rtl/param_serial_adder.sv
// Bit-serial unsigned adder: a single full-adder slice and a carry flip-flop process
// one bit per clock, LSB first, framed by a start/busy/done handshake.
module param_serial_adder #(
    parameter int SIZE  = 4,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] sum,
    output logic            carry,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   a_sh_q, a_sh_d;
    logic [SIZE-1:0]   b_sh_q, b_sh_d;
    logic [SIZE-1:0]   res_q, res_d;
    logic [SIZE-1:0]   sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              c_q, c_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              fa_s;
    logic              fa_c;
    logic [SIZE-1:0]   res_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shift-based insertion keeps the SIZE=1 case free of empty part-selects.
    always_comb begin
        fa_s      = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        fa_c      = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
        res_shift = (res_q >> 1) | (SIZE'(fa_s) << (SIZE - 1));
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shift;
                c_d    = fa_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SIZE - 1)) begin
                    sum_d   = res_shift;
                    carry_d = fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum   = sum_q;
    assign carry = carry_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_param_serial_adder.sv
// Scoreboard bench for param_serial_adder at SIZE=4, 2 and 1: expected {carry,sum}
// and the start-edge cycle are queued at issue and checked by per-instance monitors.
module tb_param_serial_adder;

    typedef struct {
        int unsigned val;
        int unsigned scyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic       start4 = 1'b0, start2 = 1'b0, start1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic [1:0] a2 = '0, b2 = '0, sum2;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       carry4, busy4, done4;
    logic       carry2, busy2, done2;
    logic       carry1, busy1, done1;

    exp_t q4[$];
    exp_t q2[$];
    exp_t q1[$];
    int unsigned held4 = 0, held2 = 0, held1 = 0;
    int unsigned d2cnt = 0;

    param_serial_adder #(.SIZE(4)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .sum(sum4), .carry(carry4), .busy(busy4), .done(done4)
    );
    param_serial_adder #(.SIZE(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .sum(sum2), .carry(carry2), .busy(busy2), .done(done2)
    );
    param_serial_adder #(.SIZE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .sum(sum1), .carry(carry1), .busy(busy1), .done(done1)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic spurious(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: done pulsed with no operation outstanding (cycle %0d)", nm, cyc);
    endtask

    // Monitors: one per instance, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            chk("u4_busy_with_done", busy4, 0);
            if (q4.size() == 0) spurious("u4_done");
            else begin
                e = q4.pop_front();
                chk("u4_result", {carry4, sum4}, e.val);
                chk("u4_latency", cyc - e.scyc, 4);
            end
        end
        if (busy4) chk("u4_hold_during_busy", {carry4, sum4}, held4);
        else held4 = {carry4, sum4};
    end

    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            d2cnt++;
            if (q2.size() == 0) spurious("u2_done");
            else begin
                e = q2.pop_front();
                chk("u2_result", {carry2, sum2}, e.val);
                chk("u2_latency", cyc - e.scyc, 2);
            end
        end
        if (busy2) chk("u2_hold_during_busy", {carry2, sum2}, held2);
        else held2 = {carry2, sum2};
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) spurious("u1_done");
            else begin
                e = q1.pop_front();
                chk("u1_result", {carry1, sum1}, e.val);
                chk("u1_latency", cyc - e.scyc, 1);
            end
        end
        if (busy1) chk("u1_hold_during_busy", {carry1, sum1}, held1);
        else held1 = {carry1, sum1};
    end

    function automatic int unsigned qsize(input int w);
        case (w)
            4: return q4.size();
            2: return q2.size();
            default: return q1.size();
        endcase
    endfunction

    task automatic wait_empty(input int w, input int lim);
        for (int i = 0; i < lim && qsize(w) != 0; i++) @(negedge clk);
        if (qsize(w) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_u%0d: %0d results outstanding, expected 0", w, qsize(w));
            case (w)
                4: q4.delete();
                2: q2.delete();
                default: q1.delete();
            endcase
        end
    endtask

    // One start pulse; operands are scrambled right after acceptance.
    task automatic op(input int w, input int unsigned av, input int unsigned bv);
        exp_t e;
        int unsigned m;
        m = (1 << w) - 1;
        @(posedge clk); #1;
        e.scyc = cyc + 1;
        e.val  = (av & m) + (bv & m);
        case (w)
            4: begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; q4.push_back(e); end
            2: begin a2 = av[1:0]; b2 = bv[1:0]; start2 = 1'b1; q2.push_back(e); end
            default: begin a1 = av[0:0]; b1 = bv[0:0]; start1 = 1'b1; q1.push_back(e); end
        endcase
        @(posedge clk); #1;
        start4 = 1'b0; start2 = 1'b0; start1 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        a2 = 2'($urandom); b2 = 2'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom);
        wait_empty(w, 4 * w + 10);
    endtask

    initial begin
        exp_t e;
        int unsigned next_acc;
        int unsigned edge_n;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int unsigned next_acc;
        int unsigned edge_n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_u4_out", {carry4, sum4, busy4, done4}, 0);
        chk("reset_u2_out", {carry2, sum2, busy2, done2}, 0);
        chk("reset_u1_out", {carry1, sum1, busy1, done1}, 0);
        @(posedge clk); #1;
        rst = 1'b0; rst4 = 1'b0;

        // Directed cases, SIZE=4
        op(4, 3, 5);
        op(4, 15, 1);
        op(4, 15, 15);

        // start held high: accepted only from IDLE, every SIZE+2 cycles
        @(posedge clk); #1;
        next_acc = 0;
        for (int j = 0; j < 18; j++) begin
            if (j != 0) begin @(posedge clk); #1; end
            a4 = (j == 0) ? 4'd2 : 4'($urandom);
            b4 = (j == 0) ? 4'd3 : 4'($urandom);
            start4 = 1'b1;
            edge_n = cyc + 1;
            if (j == 0 || edge_n == next_acc) begin
                e.scyc = edge_n;
                e.val  = int'(a4) + int'(b4);
                q4.push_back(e);
                next_acc = edge_n + 6;
            end
        end
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_empty(4, 30);

        // Reset in the middle of a run discards it
        @(posedge clk); #1;
        a4 = 4'd7; b4 = 4'd9; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4 = 1'b1;
        q4.delete();
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(negedge clk);
        chk("midreset_u4_out", {carry4, sum4, busy4, done4}, 0);
        repeat (6) @(negedge clk);
        op(4, 1, 1);

        for (int k = 0; k < 20; k++) op(4, $urandom, $urandom);

        // SIZE=2 exhaustive
        d2cnt = 0;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                op(2, x, y);
        repeat (3) @(negedge clk);
        chk("u2_done_count", d2cnt, 16);

        // SIZE=1 exhaustive
        op(1, 1, 1);
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                op(1, x, y);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
